// File: rtl/rvc_asap_pkg.sv
// Shared constants for the rvc_asap data-memory responder.
//   MMIO_*      : register offsets within the MMIO page (Addr[7:0])
//   BE_*        : right-justified byte-enable encodings for byte/half/word
//   STATUS_*    : bit positions of the fields in the STATUS register
package rvc_asap_pkg;

   localparam logic [7:0] MMIO_CYCLE_LO = 8'h00;
   localparam logic [7:0] MMIO_CYCLE_HI = 8'h04;
   localparam logic [7:0] MMIO_TOHOST   = 8'h08;
   localparam logic [7:0] MMIO_STATUS   = 8'h0C;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   localparam int STATUS_MISALIGN_BIT = 0;
   localparam int STATUS_UNMAPPED_BIT = 1;
   localparam int STATUS_ERRCNT_LSB   = 8;

endpackage

// File: rtl/rvc_asap_dmem_align.sv
// Combinational byte-lane steering for the data memory.
//   off       : in  byte offset within the word (Addr[1:0])
//   byte_en   : in  right-justified byte enables (byte/half/word)
//   wr_data   : in  right-justified store data
//   rd_word   : in  addressed RAM word
//   sign_ext  : in  sign-extend byte/half loads
//   misalign  : out access crosses its natural alignment
//   lane_mask : out RAM lanes to update on a store
//   st_data   : out store data shifted into its lanes
//   ld_data   : out extracted, masked, extended load data (0 if misaligned)
module rvc_asap_dmem_align
   import rvc_asap_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [3:0]  byte_en,
   input  logic [31:0] wr_data,
   input  logic [31:0] rd_word,
   input  logic        sign_ext,
   output logic        misalign,
   output logic [3:0]  lane_mask,
   output logic [31:0] st_data,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;
   logic [31:0] masked;

   // Word loads pass through; only byte and half results are widened.
   function automatic logic [31:0] extend(input logic [31:0] v,
                                          input logic [3:0]  be,
                                          input logic        sx);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] r;
      b = v[7:0];
      h = v[15:0];
      r = v;
      if (sx && be == BE_BYTE) r = 32'(b);
      else if (sx && be == BE_HALF) r = 32'(h);
      return r;
   endfunction

   always_comb begin
      misalign  = ((byte_en == BE_HALF) && off[0]) ||
                  ((byte_en == BE_WORD) && (off != 2'b00));
      lane_mask = byte_en << off;
      st_data   = wr_data << {off, 3'b000};
      shifted   = rd_word >> {off, 3'b000};
      masked    = shifted & {{8{byte_en[3]}}, {8{byte_en[2]}},
                             {8{byte_en[1]}}, {8{byte_en[0]}}};
      ld_data   = misalign ? 32'h0 : extend(masked, byte_en, sign_ext);
   end

endmodule

// File: rtl/rvc_asap_dmem.sv
// Data-memory responder for the single-cycle core: byte-addressable RAM with
// asynchronous read plus an MMIO page (cycle counter, TOHOST, STATUS).
//   Clock                  : in  core clock, rising edge
//   Rst                    : in  asynchronous active-high reset
//   AluOut_To_Dmem         : in  byte address
//   RegRdData2_To_Dmem     : in  right-justified store data
//   CtrlDMemByteEn_To_Dmem : in  byte enables (0001/0011/1111)
//   CtrlDMemWrEn_To_Dmem   : in  store this cycle
//   SelDMemWb_To_Dmem      : in  load this cycle
//   CtrlSignExt_To_Dmem    : in  sign-extend load result
//   DMemRdData_From_Dmem   : out combinational load data
//   Done                   : out sticky, set by a non-zero TOHOST write
//   Tohost                 : out current TOHOST value
module rvc_asap_dmem
   import rvc_asap_pkg::*;
#(
   parameter logic [31:0] D_MEM_BASE  = 32'h0000_2000,
   parameter int          D_MEM_DEPTH = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'h0000_F000
)(
   input  logic        Clock,
   input  logic        Rst,
   input  logic [31:0] AluOut_To_Dmem,
   input  logic [31:0] RegRdData2_To_Dmem,
   input  logic [3:0]  CtrlDMemByteEn_To_Dmem,
   input  logic        CtrlDMemWrEn_To_Dmem,
   input  logic        SelDMemWb_To_Dmem,
   input  logic        CtrlSignExt_To_Dmem,
   output logic [31:0] DMemRdData_From_Dmem,
   output logic        Done,
   output logic [31:0] Tohost
);

   localparam int          IDX_W     = $clog2(D_MEM_DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(4 * D_MEM_DEPTH);

   logic [31:0]      mem [D_MEM_DEPTH];
   logic [31:0]      ram_offs;
   logic [IDX_W-1:0] ram_idx;
   logic [1:0]       off;
   logic [7:0]       reg_sel;
   logic             ram_hit, mmio_hit, mmio_mis, mmio_ok;
   logic             access, ram_mis, wr_ram, mmio_wr, mmio_rd;
   logic             err_mis, err_unmapped, err_cycle;
   logic [3:0]       lane_mask;
   logic [31:0]      st_data, ram_ld, status;

   logic [63:0]      cycle_cnt;
   logic [31:0]      hi_shadow;
   logic [31:0]      tohost_q;
   logic             done_q;
   logic             misalign_err, unmapped_err;
   logic [7:0]       err_count;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Address decode; the subtraction wraps for addresses below the base,
   // so the lower-bound compare is kept explicit.
   assign ram_offs = AluOut_To_Dmem - D_MEM_BASE;
   assign ram_hit  = (AluOut_To_Dmem >= D_MEM_BASE) && (ram_offs < RAM_BYTES);
   assign ram_idx  = ram_offs[IDX_W+1:2];
   assign off      = AluOut_To_Dmem[1:0];
   assign mmio_hit = (AluOut_To_Dmem[31:8] == MMIO_BASE[31:8]);
   assign reg_sel  = AluOut_To_Dmem[7:0];

   // MMIO registers are word-only.
   assign mmio_mis = (CtrlDMemByteEn_To_Dmem != BE_WORD) || (off != 2'b00);
   assign mmio_ok  = mmio_hit && !mmio_mis;

   assign access       = CtrlDMemWrEn_To_Dmem || SelDMemWb_To_Dmem;
   assign err_mis      = access && ((ram_hit && ram_mis) || (mmio_hit && mmio_mis));
   assign err_unmapped = access && !ram_hit && !mmio_hit;
   assign err_cycle    = err_mis || err_unmapped;

   assign wr_ram  = CtrlDMemWrEn_To_Dmem && ram_hit && !ram_mis;
   assign mmio_wr = CtrlDMemWrEn_To_Dmem && mmio_ok;
   assign mmio_rd = SelDMemWb_To_Dmem && mmio_ok;

   assign status = {16'h0, err_count, 6'h0, unmapped_err, misalign_err};

   rvc_asap_dmem_align u_align (
      .off       (off),
      .byte_en   (CtrlDMemByteEn_To_Dmem),
      .wr_data   (RegRdData2_To_Dmem),
      .rd_word   (mem[ram_idx]),
      .sign_ext  (CtrlSignExt_To_Dmem),
      .misalign  (ram_mis),
      .lane_mask (lane_mask),
      .st_data   (st_data),
      .ld_data   (ram_ld)
   );

   // RAM is not reset; a store is suppressed while reset is asserted.
   always_ff @(posedge Clock) begin
      if (!Rst && wr_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) mem[ram_idx][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         cycle_cnt    <= '0;
         hi_shadow    <= '0;
         tohost_q     <= '0;
         done_q       <= 1'b0;
         misalign_err <= 1'b0;
         unmapped_err <= 1'b0;
         err_count    <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         // Reading LO snapshots HI so a LO/HI pair is coherent.
         if (mmio_rd && reg_sel == MMIO_CYCLE_LO) hi_shadow <= cycle_cnt[63:32];
         if (mmio_wr && reg_sel == MMIO_TOHOST) begin
            tohost_q <= RegRdData2_To_Dmem;
            if (RegRdData2_To_Dmem != 32'h0) done_q <= 1'b1;
         end
         // A STATUS write clears everything and wins over a same-cycle error.
         if (mmio_wr && reg_sel == MMIO_STATUS) begin
            misalign_err <= 1'b0;
            unmapped_err <= 1'b0;
            err_count    <= '0;
         end else if (err_cycle) begin
            misalign_err <= misalign_err | err_mis;
            unmapped_err <= unmapped_err | err_unmapped;
            err_count    <= sat_inc(err_count);
         end
      end
   end

   always_comb begin
      DMemRdData_From_Dmem = 32'h0;
      if (!Rst && SelDMemWb_To_Dmem) begin
         if (ram_hit) begin
            DMemRdData_From_Dmem = ram_ld;
         end else if (mmio_ok) begin
            case (reg_sel)
               MMIO_CYCLE_LO: DMemRdData_From_Dmem = cycle_cnt[31:0];
               MMIO_CYCLE_HI: DMemRdData_From_Dmem = hi_shadow;
               MMIO_TOHOST:   DMemRdData_From_Dmem = tohost_q;
               MMIO_STATUS:   DMemRdData_From_Dmem = status;
               default:       DMemRdData_From_Dmem = 32'h0;
            endcase
         end
      end
   end

   assign Done   = done_q;
   assign Tohost = tohost_q;

endmodule

// File: tb/tb_rvc_asap_dmem.sv
// Scoreboard bench for rvc_asap_dmem: stimulus pushes expected
// {load data, Done, Tohost} entries; a negedge monitor pops and compares.
module tb_rvc_asap_dmem;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        wr_en, sel_wb, sx;
   logic [31:0] rdata;
   logic        done;
   logic [31:0] tohost;

   always #5 clk = ~clk;

   rvc_asap_dmem dut (
      .Clock                  (clk),
      .Rst                    (rst),
      .AluOut_To_Dmem         (addr),
      .RegRdData2_To_Dmem     (wdata),
      .CtrlDMemByteEn_To_Dmem (be),
      .CtrlDMemWrEn_To_Dmem   (wr_en),
      .SelDMemWb_To_Dmem      (sel_wb),
      .CtrlSignExt_To_Dmem    (sx),
      .DMemRdData_From_Dmem   (rdata),
      .Done                   (done),
      .Tohost                 (tohost)
   );

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        dn;
      logic [31:0] th;
   } exp_t;

   exp_t        sb[$];
   logic        probe = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   logic        exp_done = 1'b0;
   logic [31:0] exp_tohost = 32'h0;

   localparam logic [3:0]  W = 4'b1111, H = 4'b0011, B = 4'b0001;
   localparam logic [31:0] LO = 32'hF000, HI = 32'hF004, TH = 32'hF008, ST = 32'hF00C;

   // Monitor: the probe marks a cycle whose outputs are to be checked.
   always @(negedge clk) begin
      if (probe) begin
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: output presented with no expectation queued");
         end else begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (rdata !== e.rd || done !== e.dn || tohost !== e.th) begin
               miscompares++;
               $display("FAIL %s: got rd=%h done=%b tohost=%h, want rd=%h done=%b tohost=%h",
                        e.name, rdata, done, tohost, e.rd, e.dn, e.th);
            end
         end
      end
   end

   task automatic op(input logic w, input logic s, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input logic x);
      @(posedge clk);
      #1;
      wr_en = w; sel_wb = s; addr = a; wdata = d; be = b; sx = x;
      probe = 1'b0;
   endtask

   task automatic expect_now(input string nm, input logic [31:0] rd);
      exp_t e;
      e.name = nm; e.rd = rd; e.dn = exp_done; e.th = exp_tohost;
      sb.push_back(e);
      probe = 1'b1;
   endtask

   task automatic ld(input string nm, input logic [31:0] a, input logic [3:0] b,
                     input logic x, input logic [31:0] rd);
      op(1'b0, 1'b1, a, 32'h0, b, x);
      expect_now(nm, rd);
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      op(1'b1, 1'b0, a, d, b, 1'b0);
   endtask

   task automatic idle();
      op(1'b0, 1'b0, 32'h0, 32'h0, W, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      wr_en = 1'b0; sel_wb = 1'b0; addr = 32'h0; wdata = 32'h0; be = W; sx = 1'b0;

      // Reset state: read forced to 0, Done/Tohost cleared.
      ld("reset_state", 32'h2000, W, 1'b0, 32'h0);

      // Cycle counter: ten edges out of reset.
      @(posedge clk); #1; rst = 1'b0; probe = 1'b0; sel_wb = 1'b0;
      repeat (9) idle();
      ld("cycle_lo_10", LO, W, 1'b0, 32'd10);
      ld("cycle_hi_0", HI, W, 1'b0, 32'h0);
      @(posedge clk); #1; probe = 1'b0; sel_wb = 1'b0;
      dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      ld("cycle_lo_wrap", LO, W, 1'b0, 32'h0);
      ld("cycle_hi_wrap", HI, W, 1'b0, 32'h0);

      // Word store and load.
      st(32'h2000, 32'hDEAD_BEEF, W);
      ld("lw_2000", 32'h2000, W, 1'b0, 32'hDEAD_BEEF);
      ld("status_clean", ST, W, 1'b0, 32'h0);

      // Byte store, byte/half/word loads with and without extension.
      st(32'h2003, 32'h0000_0080, B);
      ld("lb_2003", 32'h2003, B, 1'b1, 32'hFFFF_FF80);
      ld("lbu_2003", 32'h2003, B, 1'b0, 32'h0000_0080);
      ld("lw_after_sb", 32'h2000, W, 1'b0, 32'h80AD_BEEF);
      ld("lh_2002", 32'h2002, H, 1'b1, 32'hFFFF_80AD);
      ld("lhu_2002", 32'h2002, H, 1'b0, 32'h0000_80AD);
      ld("lbu_2001", 32'h2001, B, 1'b0, 32'h0000_00BE);

      // Misaligned half store is dropped and flagged.
      st(32'h2001, 32'h0000_1234, H);
      ld("lw_after_mis_sh", 32'h2000, W, 1'b0, 32'h80AD_BEEF);
      ld("status_misalign", ST, W, 1'b0, 32'h0000_0101);
      st(ST, 32'hFFFF_FFFF, W);
      ld("status_cleared", ST, W, 1'b0, 32'h0);

      // Same-cycle store and load returns the pre-edge word.
      op(1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D, W, 1'b0);
      expect_now("raw_same_cycle", 32'h80AD_BEEF);
      ld("raw_next_cycle", 32'h2000, W, 1'b0, 32'hCAFE_F00D);

      // Last RAM word, first address past the RAM, misaligned loads.
      st(32'h2FFC, 32'hA5A5_5A5A, W);
      ld("lw_last_word", 32'h2FFC, W, 1'b0, 32'hA5A5_5A5A);
      ld("lw_past_ram", 32'h3000, W, 1'b0, 32'h0);
      ld("lw_misaligned", 32'h2002, W, 1'b0, 32'h0);
      ld("mmio_half_mis", 32'hF00A, H, 1'b0, 32'h0);
      ld("mmio_other_off", 32'hF010, W, 1'b0, 32'h0);
      ld("status_mixed", ST, W, 1'b0, 32'h0000_0303);
      st(ST, 32'h0, W);

      // TOHOST / Done.
      st(TH, 32'h1, W);
      exp_done = 1'b1; exp_tohost = 32'h1;
      ld("tohost_1", TH, W, 1'b0, 32'h1);
      st(TH, 32'h0, W);
      exp_tohost = 32'h0;
      ld("tohost_0_done_sticky", TH, W, 1'b0, 32'h0);
      st(TH, 32'h55, W);
      exp_tohost = 32'h55;
      ld("tohost_55", TH, W, 1'b0, 32'h55);

      // Reset asserted mid-cycle clears outputs before the next edge.
      @(posedge clk); #1;
      wr_en = 1'b0; sel_wb = 1'b1; addr = TH; be = W;
      #1; rst = 1'b1;
      exp_done = 1'b0; exp_tohost = 32'h0;
      expect_now("mid_cycle_reset", 32'h0);
      @(posedge clk); #1; rst = 1'b0; probe = 1'b0; sel_wb = 1'b0;

      // Unmapped accesses.
      ld("lw_unmapped", 32'h8000_0000, W, 1'b0, 32'h0);
      st(32'h8000_0000, 32'h1234_5678, W);
      ld("status_unmapped", ST, W, 1'b0, 32'h0000_0202);
      ld("ram_untouched", 32'h2000, W, 1'b0, 32'hCAFE_F00D);

      idle();
      idle();
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
